// File: rtl/control_pipe_unit.sv
// Decode/control pipeline stage: registers one decoded RV32I(M) control bundle
// behind a valid/ready handshake and holds div-class ops for DIV_CYCLES cycles.
module control_pipe_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int ENABLE_M   = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    input  logic [31:0] INSTRUCTION,
    output logic        IN_READY,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    input  logic        FLUSH,
    output logic        MUX1,
    output logic        MUX2,
    output logic        MUX3,
    output logic        REGISTERWRITE,
    output logic        MEMORYWRITE,
    output logic        MEMORYREAD,
    output logic        BRANCH,
    output logic        JUMP,
    output logic        JAL,
    output logic [4:0]  ALUOP,
    output logic [2:0]  IMMEDIATE,
    output logic [2:0]  FUNCT3_OUT,
    output logic        ILLEGAL,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, HOLD, DIV_WAIT} state_t;

    typedef struct packed {
        logic       mux1;
        logic       mux2;
        logic       mux3;
        logic       regWrite;
        logic       memWrite;
        logic       memRead;
        logic       branch;
        logic       jump;
        logic       jal;
        logic       illegal;
        logic [4:0] aluOp;
        logic [2:0] imm;
        logic [2:0] funct3;
    } bundle_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    bundle_t    bundle_q, bundle_d;
    bundle_t    decoded;
    logic       isDiv;
    logic       transfer;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = INSTRUCTION[6:0];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];

    always_comb begin
        decoded         = '0;
        decoded.illegal = 1'b1;
        decoded.funct3  = funct3;
        isDiv           = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    decoded.illegal = 1'b0;
                    decoded.aluOp   = {2'b00, funct3};
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    decoded.illegal = 1'b0;
                    decoded.aluOp   = 5'b10001;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    decoded.illegal = 1'b0;
                    decoded.aluOp   = 5'b10010;
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    decoded.illegal = 1'b0;
                    decoded.aluOp   = {2'b01, funct3};
                    isDiv           = funct3[2];
                end
                if (!decoded.illegal) begin
                    decoded.mux1     = 1'b1;
                    decoded.mux2     = 1'b1;
                    decoded.regWrite = 1'b1;
                end
            end
            7'b0010011: begin
                decoded.illegal  = 1'b0;
                decoded.mux1     = 1'b1;
                decoded.regWrite = 1'b1;
                decoded.aluOp    = (funct3 == 3'b101 && funct7 == 7'b0100000) ? 5'b10010 : {2'b00, funct3};
                decoded.imm      = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b010 : 3'b001;
            end
            7'b0000011: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
                    decoded.illegal  = 1'b0;
                    decoded.mux1     = 1'b1;
                    decoded.mux3     = 1'b1;
                    decoded.regWrite = 1'b1;
                    decoded.memRead  = 1'b1;
                    decoded.imm      = 3'b001;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                    decoded.illegal  = 1'b0;
                    decoded.mux1     = 1'b1;
                    decoded.memWrite = 1'b1;
                    decoded.imm      = 3'b011;
                end
            end
            7'b1100011: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    decoded.illegal = 1'b0;
                    decoded.mux1    = 1'b1;
                    decoded.mux2    = 1'b1;
                    decoded.branch  = 1'b1;
                    decoded.aluOp   = 5'b10001;
                    decoded.imm     = 3'b100;
                end
            end
            7'b1101111: begin
                decoded.illegal  = 1'b0;
                decoded.jump     = 1'b1;
                decoded.jal      = 1'b1;
                decoded.regWrite = 1'b1;
                decoded.imm      = 3'b101;
            end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    decoded.illegal  = 1'b0;
                    decoded.jump     = 1'b1;
                    decoded.mux1     = 1'b1;
                    decoded.regWrite = 1'b1;
                    decoded.imm      = 3'b001;
                end
            end
            7'b0110111: begin
                decoded.illegal  = 1'b0;
                decoded.regWrite = 1'b1;
                decoded.aluOp    = 5'b10000;
            end
            7'b0010111: begin
                decoded.illegal  = 1'b0;
                decoded.regWrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating by RESET keeps IN_READY low while the stage is held in reset.
    assign IN_READY = RESET && !FLUSH && (state_q == IDLE || (state_q == HOLD && OUT_READY));
    assign transfer = IN_VALID && IN_READY;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        bundle_d = bundle_q;
        if (FLUSH) begin
            state_d  = IDLE;
            count_d  = '0;
            bundle_d = '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (transfer) begin
                        bundle_d = decoded;
                        if (isDiv) begin
                            state_d = DIV_WAIT;
                            count_d = DIV_LOAD;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (state_q == HOLD && OUT_READY) begin
                        state_d = IDLE;
                    end
                end
                DIV_WAIT: begin
                    if (count_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        count_d = count_q - 6'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            count_q  <= '0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            bundle_q <= bundle_d;
        end
    end

    assign OUT_VALID     = (state_q == HOLD);
    assign BUSY          = (state_q == DIV_WAIT);
    assign ILLEGAL       = bundle_q.illegal && (state_q == HOLD);
    assign MUX1          = bundle_q.mux1;
    assign MUX2          = bundle_q.mux2;
    assign MUX3          = bundle_q.mux3;
    assign REGISTERWRITE = bundle_q.regWrite;
    assign MEMORYWRITE   = bundle_q.memWrite;
    assign MEMORYREAD    = bundle_q.memRead;
    assign BRANCH        = bundle_q.branch;
    assign JUMP          = bundle_q.jump;
    assign JAL           = bundle_q.jal;
    assign ALUOP         = bundle_q.aluOp;
    assign IMMEDIATE     = bundle_q.imm;
    assign FUNCT3_OUT    = bundle_q.funct3;

endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed testbench for control_pipe_unit: handshake, decode, div wait, flush
// and asynchronous reset, with a second instance built without RV32M.
module tb_control_pipe_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic        OUT_READY = 1'b0;
    logic        FLUSH = 1'b0;

    logic        IN_READY, OUT_VALID, MUX1, MUX2, MUX3, REGISTERWRITE, MEMORYWRITE;
    logic        MEMORYREAD, BRANCH, JUMP, JAL, ILLEGAL, BUSY;
    logic [4:0]  ALUOP;
    logic [2:0]  IMMEDIATE, FUNCT3_OUT;

    logic        bInReady, bOutValid, bMux1, bMux2, bMux3, bRegWrite, bMemWrite;
    logic        bMemRead, bBranch, bJump, bJal, bIllegal, bBusy;
    logic [4:0]  bAluOp;
    logic [2:0]  bImm, bFunct3;

    int testsRun = 0;
    int testsFailed = 0;

    control_pipe_unit #(.DIV_CYCLES(4), .ENABLE_M(1)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .INSTRUCTION(INSTRUCTION),
        .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FLUSH(FLUSH),
        .MUX1(MUX1), .MUX2(MUX2), .MUX3(MUX3), .REGISTERWRITE(REGISTERWRITE),
        .MEMORYWRITE(MEMORYWRITE), .MEMORYREAD(MEMORYREAD), .BRANCH(BRANCH), .JUMP(JUMP),
        .JAL(JAL), .ALUOP(ALUOP), .IMMEDIATE(IMMEDIATE), .FUNCT3_OUT(FUNCT3_OUT),
        .ILLEGAL(ILLEGAL), .BUSY(BUSY)
    );

    control_pipe_unit #(.DIV_CYCLES(4), .ENABLE_M(0)) dutNoM (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .INSTRUCTION(INSTRUCTION),
        .IN_READY(bInReady), .OUT_VALID(bOutValid), .OUT_READY(OUT_READY), .FLUSH(FLUSH),
        .MUX1(bMux1), .MUX2(bMux2), .MUX3(bMux3), .REGISTERWRITE(bRegWrite),
        .MEMORYWRITE(bMemWrite), .MEMORYREAD(bMemRead), .BRANCH(bBranch), .JUMP(bJump),
        .JAL(bJal), .ALUOP(bAluOp), .IMMEDIATE(bImm), .FUNCT3_OUT(bFunct3),
        .ILLEGAL(bIllegal), .BUSY(bBusy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents one instruction for exactly one rising edge, then drops IN_VALID.
    task automatic applyStimulus(input logic [31:0] instr);
        IN_VALID    = 1'b1;
        INSTRUCTION = instr;
        tick();
        IN_VALID    = 1'b0;
    endtask

    logic [31:0] streamInstr [5] = '{32'h00B50533, 32'h40B50533, 32'h00B57533, 32'h00B54533, 32'h00150513};
    logic [4:0]  streamAlu   [5] = '{5'b00000, 5'b10001, 5'b00111, 5'b00100, 5'b00000};

    // Expected flags packed as {IMMEDIATE, REGISTERWRITE, MEMORYWRITE, BRANCH, JUMP, JAL}.
    logic [31:0] tblInstr [8] = '{32'h00A12023, 32'h00B50463, 32'h008000EF, 32'h000080E7,
                                  32'h12345537, 32'h00000517, 32'h40155513, 32'h00150513};
    logic [7:0]  tblFlags [8] = '{8'b011_0_1_0_0_0, 8'b100_0_0_1_0_0, 8'b101_1_0_0_1_1, 8'b001_1_0_0_1_0,
                                  8'b000_1_0_0_0_0, 8'b000_1_0_0_0_0, 8'b010_1_0_0_0_0, 8'b001_1_0_0_0_0};
    logic [4:0]  tblAlu   [8] = '{5'b00000, 5'b10001, 5'b00000, 5'b00000,
                                  5'b10000, 5'b00000, 5'b10010, 5'b00000};
    logic        tblAluChk[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    logic [31:0] illegalInstr [2] = '{32'hFFFFFFFF, 32'h00B52463};

    initial begin
        int busyCycles;
        logic sawValid;

        #1 RESET = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_out_valid", OUT_VALID, 0);
        checkOutput("reset_in_ready", IN_READY, 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_aluop", ALUOP, 0);
        tick();
        RESET     = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        checkOutput("release_in_ready", IN_READY, 1);
        tick();

        for (int i = 0; i < 5; i++) begin
            IN_VALID    = 1'b1;
            INSTRUCTION = streamInstr[i];
            @(negedge CLK);
            checkOutput("stream_in_ready", IN_READY, 1);
            if (i > 0) begin
                checkOutput("stream_out_valid", OUT_VALID, 1);
                checkOutput("stream_aluop", ALUOP, streamAlu[i-1]);
            end
            if (i == 1) begin
                checkOutput("add_mux1", MUX1, 1);
                checkOutput("add_mux2", MUX2, 1);
                checkOutput("add_regwrite", REGISTERWRITE, 1);
            end
            tick();
        end
        IN_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("stream_last_aluop", ALUOP, streamAlu[4]);
        tick();

        OUT_READY = 1'b0;
        applyStimulus(32'h0002A303);
        IN_VALID    = 1'b1;
        INSTRUCTION = 32'h00B50533;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("lw_out_valid", OUT_VALID, 1);
            checkOutput("lw_in_ready", IN_READY, 0);
            checkOutput("lw_memread", MEMORYREAD, 1);
            checkOutput("lw_memwrite", MEMORYWRITE, 0);
            checkOutput("lw_mux3", MUX3, 1);
            checkOutput("lw_imm", IMMEDIATE, 3'b001);
            checkOutput("lw_funct3", FUNCT3_OUT, 3'b010);
            tick();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        checkOutput("lw_release_in_ready", IN_READY, 1);
        tick();
        @(negedge CLK);
        checkOutput("lw_released_idle", OUT_VALID, 0);
        tick();

        applyStimulus(32'h02B54533);
        busyCycles = 0;
        sawValid   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (!BUSY) break;
            busyCycles++;
            if (OUT_VALID) sawValid = 1'b1;
        end
        checkOutput("div_busy_cycles", busyCycles, 4);
        checkOutput("div_valid_while_busy", sawValid, 0);
        checkOutput("div_out_valid", OUT_VALID, 1);
        checkOutput("div_aluop", ALUOP, 5'b01100);
        tick();

        applyStimulus(32'h02B54533);
        tick();
        FLUSH       = 1'b1;
        IN_VALID    = 1'b1;
        INSTRUCTION = 32'h00B50533;
        @(negedge CLK);
        checkOutput("flush_in_ready", IN_READY, 0);
        checkOutput("flush_busy_before", BUSY, 1);
        tick();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("flush_busy", BUSY, 0);
        checkOutput("flush_out_valid", OUT_VALID, 0);
        sawValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (OUT_VALID || BUSY) sawValid = 1'b1;
        end
        checkOutput("flush_no_bundle", sawValid, 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tblInstr[i]);
            @(negedge CLK);
            checkOutput("decode_valid", OUT_VALID, 1);
            checkOutput("decode_illegal", ILLEGAL, 0);
            checkOutput("decode_flags", {IMMEDIATE, REGISTERWRITE, MEMORYWRITE, BRANCH, JUMP, JAL}, tblFlags[i]);
            if (tblAluChk[i]) checkOutput("decode_aluop", ALUOP, tblAlu[i]);
            tick();
        end

        for (int i = 0; i < 2; i++) begin
            applyStimulus(illegalInstr[i]);
            @(negedge CLK);
            checkOutput("illegal_valid", OUT_VALID, 1);
            checkOutput("illegal_flag", ILLEGAL, 1);
            checkOutput("illegal_flags", {REGISTERWRITE, MEMORYWRITE, MEMORYREAD, BRANCH, JUMP, JAL}, 0);
            tick();
        end

        applyStimulus(32'h02B50533);
        @(negedge CLK);
        checkOutput("mul_aluop", ALUOP, 5'b01000);
        checkOutput("mul_illegal", ILLEGAL, 0);
        checkOutput("nom_mul_valid", bOutValid, 1);
        checkOutput("nom_mul_illegal", bIllegal, 1);
        checkOutput("nom_mul_regwrite", bRegWrite, 0);
        checkOutput("nom_mul_memwrite", bMemWrite, 0);
        tick();

        applyStimulus(32'h02B54533);
        #2 RESET = 1'b0;
        #1;
        checkOutput("rst_div_busy", BUSY, 0);
        checkOutput("rst_div_in_ready", IN_READY, 0);
        tick();
        tick();
        RESET = 1'b1;
        sawValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (OUT_VALID || BUSY) sawValid = 1'b1;
        end
        checkOutput("rst_div_no_bundle", sawValid, 0);
        tick();

        OUT_READY = 1'b0;
        applyStimulus(32'h00B50533);
        @(negedge CLK);
        checkOutput("rst_hold_pre_valid", OUT_VALID, 1);
        #2 RESET = 1'b0;
        #1;
        checkOutput("rst_hold_out_valid", OUT_VALID, 0);
        checkOutput("rst_hold_regwrite", REGISTERWRITE, 0);
        checkOutput("rst_hold_mux1", MUX1, 0);
        checkOutput("rst_hold_in_ready", IN_READY, 0);
        tick();
        tick();
        RESET     = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        checkOutput("rst_hold_release_ready", IN_READY, 1);
        sawValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (OUT_VALID) sawValid = 1'b1;
        end
        checkOutput("rst_hold_no_bundle", sawValid, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/control_pipe_unit.md
CONTROL_PIPE_UNIT -- requirements
Module: control_pipe_unit

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning occupancy in cycles of a div/divu/rem/remu op (legal range 1..63).
REQ-002 SHALL have parameter ENABLE_M, default 1, meaning: 1 = RV32M decoded, 0 = RV32M opcodes flagged illegal.
REQ-003 SHALL have port CLK, input, 1, meaning: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1, meaning: asynchronous active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1, meaning: INSTRUCTION is valid.
REQ-006 SHALL have port INSTRUCTION, input, 32, meaning: instruction from fetch.
REQ-007 SHALL have port IN_READY, output, 1, meaning: stage accepts an instruction this cycle.
REQ-008 SHALL have port OUT_VALID, output, 1, meaning: the registered control bundle is valid.
REQ-009 SHALL have port OUT_READY, input, 1, meaning: execute consumes the bundle this cycle.
REQ-010 SHALL have port FLUSH, input, 1, meaning: discard the held and in-progress instruction.
REQ-011 SHALL have ports MUX1, MUX2, MUX3, REGISTERWRITE, MEMORYWRITE, MEMORYREAD, BRANCH, JUMP, JAL, outputs, 1 each, all registered.
REQ-012 SHALL have ports ALUOP (output, 5), IMMEDIATE (output, 3), FUNCT3_OUT (output, 3), all registered.
REQ-013 SHALL have port ILLEGAL, output, 1, meaning: the held bundle is an undecodable instruction.
REQ-014 SHALL have port BUSY, output, 1, meaning: state is DIV_WAIT.

Function
REQ-015 SHALL implement states IDLE (empty), HOLD (bundle valid), and DIV_WAIT (div-class op counting down).
REQ-016 SHALL drive IN_READY = !FLUSH && (state==IDLE || (state==HOLD && OUT_READY)); a transfer occurs when IN_VALID && IN_READY.
REQ-017 SHALL register the decoded bundle on transfer, giving 1-cycle latency from accept to OUT_VALID for all non-div ops.
REQ-018 On transfer of div/divu/rem/remu, SHALL enter DIV_WAIT, load a counter with DIV_CYCLES-1, decrement it each cycle, and enter HOLD in the cycle after it reads 0; OUT_VALID SHALL stay 0 in DIV_WAIT.
REQ-019 In HOLD, SHALL keep all outputs stable until OUT_READY; on OUT_READY without a transfer, SHALL go to IDLE.
REQ-020 SHALL make FLUSH override everything: next state IDLE, counter cleared, and OUT_VALID, ILLEGAL and BUSY 0; a simultaneous IN_VALID SHALL be dropped.
REQ-021 SHALL use ALUOP encoding: add 00000, sll 00001, slt 00010, sltu 00011, xor 00100, srl 00101, or 00110, and 00111, mul 01000, mulh 01001, mulhsu 01010, mulhu 01011, div 01100, divu 01101, rem 01110, remu 01111, pass-B 10000, sub 10001, sra 10010.
REQ-022 SHALL decode R-type (0110011) with funct7 0000000 as base ops, 0100000 only with funct3 000/101 (sub/sra), 0000001 as M ops; flags SHALL be MUX1=1, MUX2=1, REGISTERWRITE=1, IMMEDIATE=000.
REQ-023 SHALL decode OP-IMM (0010011) with ALUOP from funct3, srai (funct7 0100000) giving 10010, MUX1=1, REGISTERWRITE=1, and IMMEDIATE=010 for funct3 001/101, else 001.
REQ-024 SHALL decode loads (0000011, funct3 000/001/010/100/101) as ALUOP 00000, MUX1=1, MUX2=0, MUX3=1, REGISTERWRITE=1, MEMORYREAD=1, IMMEDIATE=001.
REQ-025 SHALL decode stores (0100011, funct3 000/001/010) as MEMORYWRITE=1, REGISTERWRITE=0, IMMEDIATE=011.
REQ-026 SHALL decode branches (1100011, funct3 not 010/011) as BRANCH=1, ALUOP 10001, IMMEDIATE=100.
REQ-027 SHALL decode jal as JUMP=1, JAL=1, REGISTERWRITE=1, IMMEDIATE=101, and jalr (funct3 000) as JUMP=1, JAL=0, MUX1=1, REGISTERWRITE=1, IMMEDIATE=001.
REQ-028 SHALL decode lui as ALUOP 10000 and auipc as ALUOP 00000, both with MUX1=0, REGISTERWRITE=1, IMMEDIATE=000.
REQ-029 SHALL set, for any other encoding (including M ops when ENABLE_M=0), ILLEGAL=1 with all write, memory, branch and jump flags 0; such bundles SHALL still handshake normally.
REQ-030 SHALL drive FUNCT3_OUT as INSTRUCTION[14:12] registered with the bundle.

Reset
REQ-031 While RESET=0, SHALL hold state IDLE, counter 0, and every output 0 (IN_READY 0) regardless of CLK.
REQ-032 Reset assertion mid-DIV_WAIT or mid-HOLD SHALL abandon the instruction with no bundle emitted after release.
REQ-033 SHALL allow IN_READY to rise in the first cycle after RESET deasserts.

Verification
REQ-034 Bench SHALL accept 0x00B50533 (add) with OUT_READY=1: OUT_VALID in the next cycle with ALUOP=00000, MUX1=1, MUX2=1, REGISTERWRITE=1, and a back-to-back stream at 1/cycle.
REQ-035 Bench SHALL send lw 0x0002A303 with OUT_READY=0 for 3 cycles: bundle stable, IN_READY=0, MEMORYREAD=1, MEMORYWRITE=0; released on OUT_READY.
REQ-036 Bench SHALL send div 0x02B54533 with DIV_CYCLES=4: BUSY=1 for 4 cycles, then OUT_VALID=1 with ALUOP=01100.
REQ-037 Bench SHALL assert FLUSH on the 2nd DIV_WAIT cycle: next cycle IDLE, BUSY=0, OUT_VALID=0, no bundle emitted.
REQ-038 Bench SHALL send 0xFFFFFFFF, and mul with ENABLE_M=0: ILLEGAL=1 with REGISTERWRITE=MEMORYWRITE=0.
REQ-039 Bench SHALL drive RESET low mid-HOLD asynchronously: outputs 0 immediately, before the next CLK edge.
